alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares one combinational `alu` instance (64-bit AND/OR/ADD/SUB, 4-bit control) between two requesters, e.g. the execute stage and a branch-compare unit. It uses round-robin arbitration and valid/ready handshakes. Operands are registered and the ALU is evaluated for one cycle. The result and zero flag are held until the owning requester accepts them. One transaction is in flight at a time.

Parameters:
WIDTH, 64, operand/result width; must match the `alu` datapath.
CTRL_W, 4, ALU control width.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
req0_valid  input  1  requester 0 has an operation.
req0_ready  output  1  requester 0 operation accepted this cycle.
req0_in1  input  WIDTH  requester 0 operand A.
req0_in2  input  WIDTH  requester 0 operand B.
req0_ctrl  input  CTRL_W  requester 0 ALU control code.
rsp0_valid  output  1  result available for requester 0.
rsp0_ready  input  1  requester 0 consumes result.
req1_valid, req1_ready, req1_in1, req1_in2, req1_ctrl  same as req0 for requester 1.
rsp1_valid, rsp1_ready  same as rsp0 for requester 1.
rsp_result  output  WIDTH  shared result bus; valid only while rsp0_valid or rsp1_valid.
rsp_zero  output  1  zero flag of rsp_result.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: state=IDLE, rr_last=1 (requester 0 has priority first). Operand, ctrl and result registers are 0. All outputs are 0: req*_ready, rsp*_valid, rsp_result, rsp_zero, busy.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE, grant selection:
  - Only one valid: that requester is granted.
  - Both valid: the requester != rr_last is granted.
- IDLE, grant effects:
  - req<g>_ready is driven combinationally high for the granted requester only. The other ready stays 0.
  - On the same edge: latch in1, in2, ctrl and owner=g; set rr_last=g; go to EXEC.
  - Neither valid: stay in IDLE.
- EXEC (exactly 1 cycle):
  - The ALU sees the latched operands.
  - Capture alu_result into rsp_result and the zero flag into rsp_zero.
  - Go to RESP.
- RESP:
  - rsp<owner>_valid=1. The other rsp_valid stays 0.
  - rsp_result and rsp_zero are held stable.
  - When rsp<owner>_ready=1: go to IDLE.
  - All req*_ready stay 0 while in RESP.
- Latency: accepted at edge N, rsp_valid high in cycle N+2. A zero-stall back-to-back throughput is one op per 3 cycles.
- Width rules: ADD and SUB wrap modulo 2^WIDTH; carry/overflow is not reported. Ctrl codes other than AND/OR/ADD/SUB give result 0, zero=1.
- Requester stability: once valid is high, the requester holds operands stable until ready. The arbiter samples only on the ready cycle.
- A requester whose valid drops without ready loses nothing. Arbitration re-evaluates every IDLE cycle.
- rsp<x>_ready with no valid is ignored.
- Reset mid-operation, in EXEC or RESP: the transaction is discarded, no response is issued, and the reset values above apply on the next cycle.

Decomposition:
- Shared package holds:
  - ALU control constants AND=4'b0000, OR=4'b0001, ADD=4'b0010, SUB=4'b0110.
  - FSM state encoding IDLE/EXEC/RESP.
- Sub-module: the existing `alu` is instantiated once as the shared datapath.
- Round-robin selection is a small combinational block inside this module; no separate sub-module.

Test Plan:
- Single op: req0 ADD in1=5, in2=7 in cycle 1 → req0_ready in cycle 1; rsp0_valid in cycle 3 with result=12, zero=0; rsp0_ready=1 → IDLE in cycle 4.
- Contention: after reset both valid, req0 SUB 9-9 and req1 OR 0xF0|0x0F.
  - Requester 0 is granted first; its response is result=0, zero=1.
  - Requester 1 is granted next; its response is 0xFF.
  - Both valid again afterwards → requester 0 wins.
- Backpressure: hold rsp1_ready=0 for 5 cycles after rsp1_valid → result stays stable, busy=1, both req_ready=0. Release → returns to IDLE.
- Wrap and illegal ctrl:
  - ADD 0xFFFF_FFFF_FFFF_FFFF+1 → result=0, zero=1.
  - ctrl=4'b1111 → result=0, zero=1.
- Reset mid-op: assert rst during EXEC → no rsp_valid ever for that op; all outputs 0 the next cycle. A new req1 AND 0xC & 0xA then completes with result 0x8.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU-sharing arbiter.
//   - ALU control codes (AND/OR/ADD/SUB); any other code yields result 0.
//   - FSM state encoding used by alu_share_arbiter.
package alu_share_arbiter_pkg;

  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// alu: purely combinational datapath shared by the arbiter.
//   a, b    : operands (WIDTH bits)
//   ctrl    : operation select (AND/OR/ADD/SUB; others give 0)
//   result  : operation result, ADD/SUB wrap modulo 2^WIDTH
//   zero    : high when result is all zeros
module alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int CTRL_W = ALU_CTRL_W
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [CTRL_W-1:0] ctrl,
  output logic [WIDTH-1:0]  result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      default: result = '0;
    endcase
  end

  assign zero = ~|result;

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-shares one alu between two requesters.
//   clk, rst                    : clock, synchronous active-high reset
//   req<i>_valid/ready          : operation handshake (ready is combinational,
//                                 high only for the requester granted in IDLE)
//   req<i>_in1/in2/ctrl         : operands and ALU control of requester i
//   rsp<i>_valid/ready          : result handshake for the owning requester
//   rsp_result, rsp_zero        : shared result bus, held until consumed
//   busy                        : high whenever the FSM is not IDLE
// Flow: IDLE (grant + latch) -> EXEC (capture ALU output) -> RESP (hold).
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int CTRL_W = ALU_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_in1,
  input  logic [WIDTH-1:0]  req0_in2,
  input  logic [CTRL_W-1:0] req0_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_in1,
  input  logic [WIDTH-1:0]  req1_in2,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero,
  output logic              busy
);

  // Requester inputs gathered into packed arrays indexed by requester id.
  logic [1:0]             req_valid;
  logic [1:0][WIDTH-1:0]  req_in1, req_in2;
  logic [1:0][CTRL_W-1:0] req_ctrl;

  assign req_valid = {req1_valid, req0_valid};
  assign req_in1   = {req1_in1, req0_in1};
  assign req_in2   = {req1_in2, req0_in2};
  assign req_ctrl  = {req1_ctrl, req0_ctrl};

  state_t             state;
  logic               rr_last;   // requester granted most recently
  logic               owner;     // requester owning the in-flight op
  logic [WIDTH-1:0]   op_a, op_b;
  logic [CTRL_W-1:0]  op_ctrl;
  logic [WIDTH-1:0]   res_q;
  logic               zero_q;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_zero;

  logic gnt_vld;
  logic gnt;

  // Round-robin pick: a lone requester wins; on contention the one that
  // was not served last wins. Gated by rst so no handshake completes
  // during a reset cycle.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 1'b0;
    if (state == ST_IDLE && !rst) begin
      case (req_valid)
        2'b01:   begin gnt_vld = 1'b1; gnt = 1'b0;     end
        2'b10:   begin gnt_vld = 1'b1; gnt = 1'b1;     end
        2'b11:   begin gnt_vld = 1'b1; gnt = ~rr_last; end
        default: begin gnt_vld = 1'b0; gnt = 1'b0;     end
      endcase
    end
  end

  assign req0_ready = gnt_vld & ~gnt;
  assign req1_ready = gnt_vld &  gnt;

  assign rsp0_valid = (state == ST_RESP) & ~owner;
  assign rsp1_valid = (state == ST_RESP) &  owner;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign busy       = (state != ST_IDLE);

  // Only the owner's ready counts; the other side's ready is ignored.
  logic rsp_take;
  assign rsp_take = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

  alu #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .ctrl   (op_ctrl),
    .result (alu_res),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      rr_last <= 1'b1;
      owner   <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      op_ctrl <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            op_a    <= req_in1[gnt];
            op_b    <= req_in2[gnt];
            op_ctrl <= req_ctrl[gnt];
            owner   <= gnt;
            rr_last <= gnt;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q  <= alu_res;
          zero_q <= alu_zero;
          state  <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_take) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: single op, contention/round-robin,
// backpressure, wrap/illegal ctrl, and reset in the middle of an op.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [63:0] req0_in1, req0_in2, req1_in1, req1_in2, rsp_result;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        rsp_zero, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(64), .CTRL_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_ctrl(req0_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_ctrl(req1_ctrl),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic [63:0] a, input logic [63:0] b, input logic [3:0] c);
    req0_valid = v; req0_in1 = a; req0_in2 = b; req0_ctrl = c;
  endtask

  task automatic drv1(input logic v, input logic [63:0] a, input logic [63:0] b, input logic [3:0] c);
    req1_valid = v; req1_in1 = a; req1_in2 = b; req1_ctrl = c;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_rsp0v"},  rsp0_valid, 0);
    chk({tag, "_rsp1v"},  rsp1_valid, 0);
    chk({tag, "_result"}, rsp_result, 0);
    chk({tag, "_zero"},   rsp_zero, 0);
    chk({tag, "_rdy0"},   req0_ready, 0);
    chk({tag, "_rdy1"},   req1_ready, 0);
  endtask

  initial begin
    rst = 1'b1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    drv0(1'b0, 0, 0, 4'h0);
    drv1(1'b0, 0, 0, 4'h0);

    // Reset state; a valid request during reset must not see ready.
    tick(); tick();
    drv0(1'b1, 64'd1, 64'd1, 4'b0010);
    #1;
    chk_idle_zero("reset");
    drv0(1'b0, 0, 0, 4'h0);
    rst = 1'b0;

    // Single op: ADD 5+7, accepted in cycle 1, response two edges later.
    tick();
    drv0(1'b1, 64'd5, 64'd7, 4'b0010);
    #1;
    chk("single_rdy0", req0_ready, 1);
    chk("single_rdy1", req1_ready, 0);
    chk("single_idle_busy", busy, 0);
    tick();
    drv0(1'b0, 0, 0, 4'h0);
    chk("single_exec_busy", busy, 1);
    chk("single_exec_rsp0v", rsp0_valid, 0);
    tick();
    chk("single_rsp0v", rsp0_valid, 1);
    chk("single_rsp1v", rsp1_valid, 0);
    chk("single_result", rsp_result, 64'd12);
    chk("single_zero", rsp_zero, 0);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    chk("single_done_busy", busy, 0);
    chk("single_done_rsp0v", rsp0_valid, 0);

    // Contention after reset: requester 0 goes first.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drv0(1'b1, 64'd9, 64'd9, 4'b0110);
    drv1(1'b1, 64'hF0, 64'h0F, 4'b0001);
    #1;
    chk("cont_rdy0", req0_ready, 1);
    chk("cont_rdy1", req1_ready, 0);
    tick();
    drv0(1'b0, 0, 0, 4'h0);
    #1;
    chk("cont_exec_rdy1", req1_ready, 0);
    tick();
    chk("cont_r0_rsp0v", rsp0_valid, 1);
    chk("cont_r0_rsp1v", rsp1_valid, 0);
    chk("cont_r0_result", rsp_result, 0);
    chk("cont_r0_zero", rsp_zero, 1);
    chk("cont_r0_rdy1", req1_ready, 0);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    chk("cont_r1_rdy1", req1_ready, 1);
    chk("cont_r1_rdy0", req0_ready, 0);
    tick();
    drv1(1'b0, 0, 0, 4'h0);
    tick();
    chk("cont_r1_rsp1v", rsp1_valid, 1);
    chk("cont_r1_rsp0v", rsp0_valid, 0);
    chk("cont_r1_result", rsp_result, 64'hFF);
    chk("cont_r1_zero", rsp_zero, 0);

    // Backpressure: result held, no new grants even with a pending request.
    drv0(1'b1, 64'd1, 64'd2, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_result", rsp_result, 64'hFF);
      chk("bp_busy", busy, 1);
      chk("bp_rsp1v", rsp1_valid, 1);
      chk("bp_rdy0", req0_ready, 0);
      chk("bp_rdy1", req1_ready, 0);
    end
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;
    chk("bp_release_busy", busy, 0);

    // Both valid again: last grant was 1, so requester 0 wins. ADD wraps.
    drv0(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010);
    drv1(1'b1, 64'd3, 64'd5, 4'b1111);
    #1;
    chk("rr_rdy0", req0_ready, 1);
    chk("rr_rdy1", req1_ready, 0);
    tick();
    drv0(1'b0, 0, 0, 4'h0);
    tick();
    chk("wrap_rsp0v", rsp0_valid, 1);
    chk("wrap_result", rsp_result, 0);
    chk("wrap_zero", rsp_zero, 1);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;

    // Contention with last grant 0: requester 1 wins; illegal ctrl.
    drv0(1'b1, 64'd4, 64'd4, 4'b0000);
    #1;
    chk("rr2_rdy1", req1_ready, 1);
    chk("rr2_rdy0", req0_ready, 0);
    tick();
    drv0(1'b0, 0, 0, 4'h0);
    drv1(1'b0, 0, 0, 4'h0);
    tick();
    chk("illegal_rsp1v", rsp1_valid, 1);
    chk("illegal_result", rsp_result, 0);
    chk("illegal_zero", rsp_zero, 1);
    // The non-owner's ready must not complete the response.
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    chk("wrong_ready_busy", busy, 1);
    chk("wrong_ready_rsp1v", rsp1_valid, 1);
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;
    chk("illegal_done_busy", busy, 0);

    // Reset while in EXEC: op discarded, outputs cleared next cycle.
    drv0(1'b1, 64'hFF, 64'hFF, 4'b0000);
    tick();
    drv0(1'b0, 0, 0, 4'h0);
    chk("mid_exec_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_zero("midrst");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_rsp0", rsp0_valid, 0);
    end

    // Fresh op after the aborted one.
    drv1(1'b1, 64'hC, 64'hA, 4'b0000);
    #1;
    chk("post_rdy1", req1_ready, 1);
    tick();
    drv1(1'b0, 0, 0, 4'h0);
    tick();
    chk("post_rsp1v", rsp1_valid, 1);
    chk("post_result", rsp_result, 64'h8);
    chk("post_zero", rsp_zero, 0);
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;
    chk("post_done_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
